// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and the register bank (slave).
interface apb_slave_regbank_if #(
    parameter int NUM_SEL = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
);
    logic [NUM_SEL-1:0]  Pselx;
    logic                Penable;
    logic                Pwrite;
    logic [ADDR_W-1:0]   Paddr;
    logic [DATA_W-1:0]   Pwdata;
    logic [DATA_W/8-1:0] Pstrb;
    logic [DATA_W-1:0]   Prdata;
    logic                Pready;
    logic                Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB slave endpoint: NUM_SEL channels of NUM_REGS read/write registers with
// programmable wait states, byte strobes and slave-error signalling.
module apb_slave_regbank #(
    parameter int               NUM_SEL     = 3,
    parameter int               NUM_REGS    = 8,
    parameter int               DATA_W      = 32,
    parameter int               ADDR_W      = 32,
    parameter int               WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    apb_slave_regbank_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int CH_W   = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] regs [NUM_SEL][NUM_REGS];
    logic [CH_W-1:0]   ch_q;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [CH_W-1:0]   ch_now;
    logic [IDX_W-1:0]  idx_now;
    logic              err_now;
    logic              sel_any;
    logic              done;

    function automatic logic [CH_W-1:0] sel_to_ch(input logic [NUM_SEL-1:0] sel);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (sel[i]) ch = CH_W'(i);
        end
        return ch;
    endfunction

    // Errors: non-one-hot select, word index past the bank, or misaligned byte address.
    assign ch_now  = sel_to_ch(bus.Pselx);
    assign idx_now = bus.Paddr[2 +: IDX_W];
    assign err_now = !$onehot(bus.Pselx)
                  || (bus.Paddr[ADDR_W-1:2] >= (ADDR_W-2)'(NUM_REGS))
                  || (bus.Paddr[1:0] != 2'b00);
    assign sel_any = |bus.Pselx;
    assign done    = (state == ACCESS) && (wait_cnt == 4'(WAIT_STATES));

    assign bus.Pready  = done;
    assign bus.Pslverr = done && err_q;
    assign bus.Prdata  = rdata_q;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ch_q     <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            for (int c = 0; c < NUM_SEL; c++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs[c][r] <= RESET_VAL;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    rdata_q  <= '0;
                    if (sel_any && !bus.Penable) state <= SETUP;
                end
                SETUP: begin
                    ch_q     <= ch_now;
                    idx_q    <= idx_now;
                    write_q  <= bus.Pwrite;
                    err_q    <= err_now;
                    wait_cnt <= '0;
                    rdata_q  <= (bus.Pwrite || err_now) ? '0 : regs[ch_now][idx_now];
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        // Write data and strobes are taken from the completion cycle.
                        if (write_q && !err_q) begin
                            for (int b = 0; b < STRB_W; b++) begin
                                if (bus.Pstrb[b]) regs[ch_q][idx_q][b*8 +: 8] <= bus.Pwdata[b*8 +: 8];
                            end
                        end
                        rdata_q <= '0;
                        state   <= (sel_any && !bus.Penable) ? SETUP : IDLE;
                    end else if (!sel_any || !bus.Penable) begin
                        rdata_q <= '0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: three register banks (0, 3 and 2 wait states) on one shared
// bus; only the targeted instance sees Pselx.
module tb_apb_slave_regbank;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  sel;
    logic        en, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    int          tgt;

    apb_slave_regbank_if #(.NUM_SEL(3), .DATA_W(32), .ADDR_W(32)) bus0 ();
    apb_slave_regbank_if #(.NUM_SEL(3), .DATA_W(32), .ADDR_W(32)) bus3 ();
    apb_slave_regbank_if #(.NUM_SEL(3), .DATA_W(32), .ADDR_W(32)) bus2 ();

    assign bus0.Pselx = (tgt == 0) ? sel : 3'b000;
    assign bus3.Pselx = (tgt == 1) ? sel : 3'b000;
    assign bus2.Pselx = (tgt == 2) ? sel : 3'b000;
    assign bus0.Penable = en;  assign bus3.Penable = en;  assign bus2.Penable = en;
    assign bus0.Pwrite  = wr;  assign bus3.Pwrite  = wr;  assign bus2.Pwrite  = wr;
    assign bus0.Paddr   = addr; assign bus3.Paddr  = addr; assign bus2.Paddr  = addr;
    assign bus0.Pwdata  = wdata; assign bus3.Pwdata = wdata; assign bus2.Pwdata = wdata;
    assign bus0.Pstrb   = strb; assign bus3.Pstrb  = strb; assign bus2.Pstrb  = strb;

    apb_slave_regbank #(.WAIT_STATES(0)) u_ws0 (.Hclk(clk), .Hresetn(rst_n), .bus(bus0));
    apb_slave_regbank #(.WAIT_STATES(3)) u_ws3 (.Hclk(clk), .Hresetn(rst_n), .bus(bus3));
    apb_slave_regbank #(.WAIT_STATES(2)) u_ws2 (.Hclk(clk), .Hresetn(rst_n), .bus(bus2));

    logic [31:0] rdata;
    logic        ready, slverr;
    always_comb begin
        case (tgt)
            1:       begin rdata = bus3.Prdata; ready = bus3.Pready; slverr = bus3.Pslverr; end
            2:       begin rdata = bus2.Prdata; ready = bus2.Pready; slverr = bus2.Pslverr; end
            default: begin rdata = bus0.Prdata; ready = bus0.Pready; slverr = bus0.Pslverr; end
        endcase
    end

    int pulses2 = 0;
    always @(negedge clk) if (bus2.Pready) pulses2++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(inout int cyc);
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ready && cyc < 40);
        if (!ready) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic xfer(input int t, input logic [2:0] s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int cyc);
        @(posedge clk); #1;
        tgt = t; sel = s; en = 1'b0; wr = w; addr = a; wdata = d; strb = st;
        @(posedge clk); #1;
        en  = 1'b1;
        cyc = 1;
        wait_ready(cyc);
        rd = rdata;
        er = slverr;
        @(posedge clk); #1;
        sel = 3'b000; en = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc, pa;

    initial begin
        tgt = 0; sel = '0; en = 0; wr = 0; addr = '0; wdata = '0; strb = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_slverr", 32'(slverr), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        xfer(0, 3'b001, 0, 32'h0C, 32'h0, 4'h0, rd, er, cyc);
        chk("rst_read_data", rd, 32'h0);
        chk("rst_read_cycles", 32'(cyc), 32'd2);
        chk("rst_read_err", 32'(er), 32'd0);

        // Byte strobes merge into an existing word
        xfer(0, 3'b010, 1, 32'h08, 32'hDEADBEEF, 4'hF, rd, er, cyc);
        xfer(0, 3'b010, 1, 32'h08, 32'h00001234, 4'h3, rd, er, cyc);
        xfer(0, 3'b010, 0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("strb_merge", rd, 32'hDEAD1234);
        chk("rd_clear_after", rdata, 32'h0);
        xfer(0, 3'b001, 0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("ch0_isolated", rd, 32'h0);
        xfer(0, 3'b100, 0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("ch2_isolated", rd, 32'h0);

        // Error responses
        xfer(0, 3'b011, 1, 32'h08, 32'h00000055, 4'hF, rd, er, cyc);
        chk("multisel_err", 32'(er), 32'd1);
        xfer(0, 3'b010, 0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("multisel_ch1_kept", rd, 32'hDEAD1234);
        chk("good_read_no_err", 32'(er), 32'd0);
        xfer(0, 3'b001, 0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("multisel_ch0_kept", rd, 32'h0);
        xfer(0, 3'b001, 1, 32'h00, 32'h77777777, 4'hF, rd, er, cyc);
        xfer(0, 3'b001, 0, 32'h21, 32'h0, 4'h0, rd, er, cyc);
        chk("misalign_err", 32'(er), 32'd1);
        chk("misalign_data", rd, 32'h0);
        xfer(0, 3'b001, 0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
        chk("range_err", 32'(er), 32'd1);
        chk("range_data", rd, 32'h0);
        xfer(0, 3'b001, 0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
        chk("ch0_idx0_read", rd, 32'h77777777);
        xfer(0, 3'b010, 1, 32'h08, 32'hFFFFFFFF, 4'h0, rd, er, cyc);
        chk("strb0_no_err", 32'(er), 32'd0);
        xfer(0, 3'b010, 0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("strb0_noop", rd, 32'hDEAD1234);

        // Three wait states: SETUP + 3 stalled ACCESS + completing ACCESS
        xfer(1, 3'b100, 1, 32'h04, 32'h12345678, 4'hF, rd, er, cyc);
        chk("ws3_write_cycles", 32'(cyc), 32'd5);
        xfer(1, 3'b100, 0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        chk("ws3_read_cycles", 32'(cyc), 32'd5);
        chk("ws3_read_data", rd, 32'h12345678);
        chk("ws3_rd_clear", rdata, 32'h0);

        // Abort: select dropped in the first ACCESS cycle
        @(posedge clk); #1;
        tgt = 2; sel = 3'b001; en = 0; wr = 1; addr = 32'h0; wdata = 32'hCAFEF00D; strb = 4'hF;
        @(posedge clk); #1;
        en = 1;
        @(posedge clk); #1;
        chk("abort_acc_ready", 32'(ready), 32'd0);
        sel = 3'b000;
        pa = pulses2;
        repeat (4) @(posedge clk);
        #1;
        en = 0;
        chk("abort_no_pulse", 32'(pulses2 - pa), 32'd0);
        xfer(2, 3'b001, 0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
        chk("abort_reg_kept", rd, 32'h0);
        chk("ws2_read_cycles", 32'(cyc), 32'd4);

        // Back-to-back writes with no IDLE gap
        pa = pulses2;
        @(posedge clk); #1;
        sel = 3'b001; en = 0; wr = 1; addr = 32'h04; wdata = 32'h11111111; strb = 4'hF;
        @(posedge clk); #1;
        en = 1; cyc = 1;
        wait_ready(cyc);
        sel = 3'b100; en = 0; addr = 32'h14;
        @(posedge clk); #1;
        en = 1; wdata = 32'h22222222; cyc = 1;
        wait_ready(cyc);
        @(posedge clk); #1;
        sel = 3'b000; en = 0;
        @(negedge clk);
        chk("b2b_pulses", 32'(pulses2 - pa), 32'd2);
        xfer(2, 3'b001, 0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        chk("b2b_first", rd, 32'h11111111);
        xfer(2, 3'b100, 0, 32'h14, 32'h0, 4'h0, rd, er, cyc);
        chk("b2b_second", rd, 32'h22222222);

        // Reset asserted in the completing ACCESS cycle
        @(posedge clk); #1;
        tgt = 0; sel = 3'b100; en = 0; wr = 1; addr = 32'h1C; wdata = 32'hA5A5A5A5; strb = 4'hF;
        @(posedge clk); #1;
        en = 1;
        @(posedge clk); #1;
        chk("mr_ready_before", 32'(ready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_ready_in_rst", 32'(ready), 32'd0);
        @(posedge clk); #1;
        sel = 3'b000; en = 0;
        rst_n = 1'b1;
        xfer(0, 3'b100, 0, 32'h1C, 32'h0, 4'h0, rd, er, cyc);
        chk("mr_write_lost", rd, 32'h0);
        xfer(0, 3'b010, 0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("mr_regs_reset", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
